// File: rtl/perf_pkg.sv
// ----------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the performance counter block.
//   state_t   : control FSM encoding (IDLE=0, RUN=1, FROZEN=2)
//   RD_SEL_W  : width of the read-select bus
// ----------------------------------------------------------------------------
package perf_pkg;

    localparam int RD_SEL_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

endpackage

// File: rtl/perf_cnt_ch.sv
// ----------------------------------------------------------------------------
// perf_cnt_ch
// One event counter with a sticky overflow flag.
// Configuration macro: PERF_SAT_EN
//   defined   -> counter saturates at all-ones
//   undefined -> counter wraps from all-ones to zero
// In both builds an increment attempted at all-ones sets the sticky ovf flag.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   clr    in   zero count and ovf (wins over inc)
//   inc    in   add one this cycle
//   count  out  current count value
//   ovf    out  sticky overflow flag
// ----------------------------------------------------------------------------
module perf_cnt_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    assign at_max = &count_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf_d = 1'b1;
`ifdef PERF_SAT_EN
                count_d = count_q;
`else
                count_d = '0;
`endif
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_counters.sv
// ----------------------------------------------------------------------------
// perf_counters
// NUM_CH event counters plus one free-running cycle counter, all gated by a
// small IDLE/RUN/FROZEN control FSM, with a registered one-cycle read port.
// Configuration macro: PERF_SAT_EN (saturate instead of wrap, see perf_cnt_ch)
// Parameters:
//   NUM_CH  number of event channels (1..16)
//   CNT_W   counter width (8..48)
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   pulse: IDLE -> RUN
//   halt      in   pulse: RUN -> FROZEN
//   clear     in   pulse: zero counters/ovf, go to IDLE (highest priority)
//   event_in  in   per-channel event strobes
//   rd_en     in   read request
//   rd_sel    in   channel select; NUM_CH selects the cycle counter
//   rd_data   out  read result (one cycle after rd_en)
//   rd_valid  out  qualifies rd_data
//   rd_err    out  rd_sel was out of range
//   ovf       out  sticky overflow flags; bit NUM_CH is the cycle counter
//   state_o   out  current FSM state encoding
// ----------------------------------------------------------------------------
module perf_counters
    import perf_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt,
    input  logic                clear,
    input  logic [NUM_CH-1:0]   event_in,
    input  logic                rd_en,
    input  logic [RD_SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic                rd_valid,
    output logic                rd_err,
    output logic [NUM_CH:0]     ovf,
    output logic [1:0]          state_o
);

    state_t state_q, state_d;

    logic             count_en;
    logic [NUM_CH:0]  inc_vec;
    logic [CNT_W-1:0] cnt [NUM_CH+1];

    logic [CNT_W-1:0] rd_mux;
    logic             rd_oor;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start) state_d = ST_RUN;
                ST_RUN:    if (halt)  state_d = ST_FROZEN;
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Counting keys off the registered state only: the start cycle is still
    // IDLE (no count) and the halt cycle is still RUN (counts once more).
    always_comb begin
        count_en = (state_q == ST_RUN);
        state_o  = state_q;
        inc_vec  = {count_en, event_in & {NUM_CH{count_en}}};
    end

    // ---------------- counters ----------------
    // Index NUM_CH is the cycle counter; its increment is just count_en.
    for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
        perf_cnt_ch #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clear),
            .inc   (inc_vec[g]),
            .count (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    // ---------------- read port ----------------
    // The mux reads the counter registers, so a read alongside an increment
    // returns the value before that increment lands.
    always_comb begin
        rd_oor = (rd_sel > RD_SEL_W'(NUM_CH));
        rd_mux = '0;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (rd_sel == RD_SEL_W'(i)) begin
                rd_mux = cnt[i];
            end
        end
        rd_valid_d = rd_en;
        rd_err_d   = rd_en && rd_oor;
        rd_data_d  = (rd_en && !rd_oor) ? rd_mux : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_perf_counters.sv
// ----------------------------------------------------------------------------
// tb_perf_counters
// Self-checking bench for perf_counters (NUM_CH=4, CNT_W=8). A count-level
// model tracks state, counts, ovf and the expected read result; a compare
// process checks the DUT against it every cycle, and directed sequences add
// literal expectations. Honours PERF_SAT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_perf_counters;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              halt;
    logic              clear;
    logic [NUM_CH-1:0] event_in;
    logic              rd_en;
    logic [4:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic [NUM_CH:0]   ovf;
    logic [1:0]        state_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // model state
    int               m_state;
    int               m_cnt [NUM_CH+1];
    logic [NUM_CH:0]  m_ovf;
    logic             m_valid;
    logic             m_err;
    logic [CNT_W-1:0] m_data;

    perf_counters #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .halt     (halt),
        .clear    (clear),
        .event_in (event_in),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .ovf      (ovf),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task model_update();
        int idx;
        bit oor;
        logic [NUM_CH:0] hits;
        if (!rst_n) begin
            m_state = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf   = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_data  = '0;
            return;
        end
        idx     = int'(rd_sel);
        oor     = (idx > NUM_CH);
        m_valid = rd_en;
        m_err   = rd_en && oor;
        m_data  = (rd_en && !oor) ? CNT_W'(m_cnt[idx]) : '0;
        if (clear) begin
            m_state = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = '0;
        end else begin
            if (m_state == 1) begin
                hits = {1'b1, event_in};
                for (int i = 0; i <= NUM_CH; i++) begin
                    if (hits[i]) begin
                        if (m_cnt[i] == MAXV) begin
                            m_ovf[i] = 1'b1;
`ifdef PERF_SAT_EN
                            m_cnt[i] = MAXV;
`else
                            m_cnt[i] = 0;
`endif
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                end
            end
            if (m_state == 0 && start)     m_state = 1;
            else if (m_state == 1 && halt) m_state = 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic applyIdle();
        start = 0; halt = 0; clear = 0; event_in = '0; rd_en = 0; rd_sel = '0;
    endtask

    task automatic pulse_clear_start();
        clear = 1; tick(); clear = 0;
        start = 1; tick(); start = 0;
    endtask

    task automatic read_lit(input string name, input int sel, input int exp_data, input bit exp_err);
        rd_en = 1; rd_sel = 5'(sel);
        tick();
        rd_en = 0;
        check({name, "_valid"}, 64'(rd_valid), 64'(1));
        check({name, "_data"},  64'(rd_data),  64'(exp_data));
        check({name, "_err"},   64'(rd_err),   64'(exp_err));
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 64'(state_o), 64'(m_state));
            check("ovf", 64'(ovf), 64'(m_ovf));
            check("rd_valid", 64'(rd_valid), 64'(m_valid));
            if (m_valid) begin
                check("rd_data", 64'(rd_data), 64'(m_data));
                check("rd_err", 64'(rd_err), 64'(m_err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // directed table used in the mixed-pattern phase
    logic [3:0] tv_ev  [8] = '{4'b1111, 4'b0011, 4'b1010, 4'b0000, 4'b0110, 4'b1111, 4'b0001, 4'b1000};
    logic       tv_rd  [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
    logic [4:0] tv_sel [8] = '{5'd0, 5'd1, 5'd0, 5'd4, 5'd2, 5'd0, 5'd3, 5'd6};
    logic       tv_st  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        int exp_ch0, exp_cyc;
        applyIdle();
        rst_n = 0;
        tick();
        chk_en = 1;
        tick();
        check("reset_state", 64'(state_o), 64'(0));
        check("reset_valid", 64'(rd_valid), 64'(0));
        check("reset_err",   64'(rd_err),   64'(0));
        check("reset_data",  64'(rd_data),  64'(0));
        check("reset_ovf",   64'(ovf),      64'(0));
        rst_n = 1;
        tick();

        // halt while IDLE is ignored
        halt = 1; tick(); halt = 0;
        check("halt_in_idle", 64'(state_o), 64'(0));

        // basic count: events 0101 for 10 cycles, halt cycle quiet
        start = 1; tick(); start = 0;
        event_in = 4'b0101;
        repeat (10) tick();
        event_in = 4'b0000;
        halt = 1; tick(); halt = 0;
        check("frozen_state", 64'(state_o), 64'(2));
        read_lit("b_ch0", 0, 10, 0);
        read_lit("b_ch1", 1, 0, 0);
        read_lit("b_ch2", 2, 10, 0);
        read_lit("b_ch3", 3, 0, 0);
        read_lit("b_cyc", 4, 11, 0);

        // halt cycle still counts, later events do not
        pulse_clear_start();
        event_in = 4'b0001;
        repeat (3) tick();
        halt = 1; tick(); halt = 0;
        repeat (3) tick();
        event_in = 4'b0000;
        check("halt_frozen", 64'(state_o), 64'(2));
        read_lit("h_ch0", 0, 4, 0);
        read_lit("h_cyc", 4, 4, 0);

        // out-of-range read, then back-to-back reads
        read_lit("oor5", NUM_CH + 1, 0, 1);
        read_lit("oor31", 31, 0, 1);
        rd_en = 1; rd_sel = 5'd0; tick();
        check("b2b0_valid", 64'(rd_valid), 64'(1));
        check("b2b0_data",  64'(rd_data),  64'(4));
        rd_sel = 5'd1; tick();
        rd_en = 0;
        check("b2b1_valid", 64'(rd_valid), 64'(1));
        check("b2b1_data",  64'(rd_data),  64'(0));
        tick();
        check("rd_idle_valid", 64'(rd_valid), 64'(0));

        // clear beats start and events
        clear = 1; start = 1; event_in = 4'b1111; tick();
        clear = 0; start = 0; event_in = 4'b0000;
        check("clr_state", 64'(state_o), 64'(0));
        check("clr_ovf",   64'(ovf),     64'(0));
        for (int i = 0; i <= NUM_CH; i++) read_lit("clr_rd", i, 0, 0);

        // mixed patterns, reads overlapping increments, start ignored in RUN
        start = 1; tick(); start = 0;
        for (int i = 0; i < 8; i++) begin
            event_in = tv_ev[i]; rd_en = tv_rd[i]; rd_sel = tv_sel[i]; start = tv_st[i];
            tick();
        end
        applyIdle();
        halt = 1; tick(); halt = 0;
        read_lit("mix_ch0", 0, 4, 0);
        read_lit("mix_ch3", 3, 4, 0);
        read_lit("mix_cyc", 4, 9, 0);

        // overflow of an 8-bit counter
        pulse_clear_start();
        event_in = 4'b0001;
        repeat (256) tick();
        event_in = 4'b0000;
        halt = 1; tick(); halt = 0;
`ifdef PERF_SAT_EN
        exp_ch0 = 255; exp_cyc = 255;
`else
        exp_ch0 = 0; exp_cyc = 1;
`endif
        check("ovf_bit0", 64'(ovf[0]), 64'(1));
        check("ovf_bit1", 64'(ovf[1]), 64'(0));
        check("ovf_cyc",  64'(ovf[NUM_CH]), 64'(1));
        read_lit("ovf_ch0", 0, exp_ch0, 0);
        read_lit("ovf_cycrd", 4, exp_cyc, 0);

        // reset mid-RUN with a pending read and live events
        pulse_clear_start();
        event_in = 4'b1111;
        repeat (3) tick();
        rst_n = 0; rd_en = 1; rd_sel = 5'd0;
        tick();
        rst_n = 1; rd_en = 0; event_in = 4'b0000;
        check("rst_run_state", 64'(state_o), 64'(0));
        check("rst_run_valid", 64'(rd_valid), 64'(0));
        check("rst_run_ovf",   64'(ovf),      64'(0));
        for (int i = 0; i <= NUM_CH; i++) read_lit("rst_rd", i, 0, 0);

        tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
